// File: rtl/cs_resolver.sv
// Digit-serial carry-propagate adder resolving a sum/carry vector pair into one binary result.
// Optional macro CS_RESOLVER_EARLY_DONE_EN: finish as soon as the remaining slices are all zero.
module cs_resolver #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             busy
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned SW = DIGIT + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_d;
  logic [WIDTH-1:0] s_q, c_q;
  logic [CW-1:0]    cnt;
  logic             carry_q;

  logic [31:0]      base_c;
  logic [DIGIT-1:0] s_sl_c, c_sl_c;
  logic [DIGIT:0]   slice_c;
  logic             last_c, early_c, accept_c, finish_c;

  // Current slice: operands shifted down by the slice base, plus the rippled carry
  assign base_c   = 32'(cnt) * 32'(DIGIT);
  assign s_sl_c   = DIGIT'(s_q >> base_c);
  assign c_sl_c   = DIGIT'(c_q >> base_c);
  assign slice_c  = SW'(s_sl_c) + SW'(c_sl_c) + SW'(carry_q);
  assign last_c   = (cnt == CW'(N - 1));
  assign accept_c = (state == IDLE) && in_valid && in_ready;

`ifdef CS_RESOLVER_EARLY_DONE_EN
  logic [WIDTH-1:0] rem_c;
  // Nothing left to add and no carry pending: the upper result bits are already zero
  assign rem_c   = (s_q | c_q) >> (base_c + 32'(DIGIT));
  assign early_c = !slice_c[DIGIT] && (rem_c == '0);
`else
  assign early_c = 1'b0;
`endif

  assign finish_c = (state == RUN) && (last_c || early_c);

  // State register with registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept_c) state_d = RUN;
      RUN:     if (finish_c) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and per-slice accumulation; result bits are written exactly once per op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      c_q     <= '0;
      result  <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
    end else if (accept_c) begin
      s_q     <= sum_vec;
      c_q     <= carry_vec;
      result  <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
    end else if (state == RUN) begin
      result  <= result | (RW'(slice_c[DIGIT-1:0]) << base_c);
      carry_q <= slice_c[DIGIT];
      cnt     <= cnt + CW'(1);
      if (last_c) result[WIDTH] <= slice_c[DIGIT];
    end
  end

endmodule

// File: tb/tb_cs_resolver.sv
// Directed self-checking bench for cs_resolver: latency, arithmetic, backpressure, async reset.
`timescale 1ns/1ps
module tb_cs_resolver;

  localparam int unsigned WIDTH = 16;
`ifdef CS_RESOLVER_EARLY_DONE_EN
  localparam int EXP_SMALL_LAT = 1;
`else
  localparam int EXP_SMALL_LAT = 4;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_vec;
  logic [WIDTH-1:0] carry_vec;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             busy;

  int checks = 0;
  int errors = 0;

  cs_resolver #(.WIDTH(16), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_vec   (sum_vec),
    .carry_vec (carry_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand pair through the accept edge; returns with in_valid low
  task automatic accept(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
    in_valid  = 1'b1;
    sum_vec   = s;
    carry_vec = c;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid, bounded; tracks busy in between
  task automatic wait_out(output int cycles, output bit busy_ok);
    cycles  = 0;
    busy_ok = 1'b1;
    while (!out_valid && cycles < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sum_vec = '0; carry_vec = '0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 17'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h, want 1 0 0 00000",
               in_ready, out_valid, busy, result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add(input string name, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                          input logic [WIDTH:0] exp, input int exp_lat, input bit do_drain);
    int cyc;
    bit bok;
    accept(s, c);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept: busy=%b in_ready=%b, want 1 0", name, busy, in_ready);
    end
    wait_out(cyc, bok);
    checks++;
    if (cyc !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, want %0d", name, cyc, exp_lat);
    end
    checks++;
    if (!bok) begin
      errors++;
      $display("FAIL %s_busy: busy dropped before out_valid, want 1", name);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s_result: got %h, want %h", name, result, exp);
    end
    if (do_drain) begin
      drain();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_drain: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
                 name, out_valid, in_ready, busy);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit bok;
    test_add("bp_first", 16'h1234, 16'h0F0F, 17'h02143, 4, 1'b0);
    in_valid = 1'b1; sum_vec = 16'h0001; carry_vec = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== 17'h02143 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: result=%h in_ready=%b out_valid=%b, want 02143 0 1",
                 i, result, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept2: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    wait_out(cyc, bok);
    checks++;
    if (cyc !== 4 || result !== 17'h00002) begin
      errors++;
      $display("FAIL bp_second: latency=%0d result=%h, want 4 00002", cyc, result);
    end
    drain();
  endtask

  task automatic test_async_reset();
    accept(16'hAAAA, 16'h5555);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 17'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b result=%h in_ready=%b busy=%b, want 0 00000 1 0",
               out_valid, result, in_ready, busy);
    end
    #13 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset%0d: out_valid=%b busy=%b, want 0 0", i, out_valid, busy);
      end
    end
    test_add("after_reset", 16'hAAAA, 16'h5555, 17'h0FFFF, 4, 1'b1);
  endtask

  initial begin
    test_reset();
    test_add("basic", 16'h1234, 16'h0F0F, 17'h02143, 4, 1'b1);
    test_add("ripple", 16'hFFFF, 16'h0001, 17'h10000, 4, 1'b1);
    test_add("max", 16'hFFFF, 16'hFFFF, 17'h1FFFE, 4, 1'b1);
    test_backpressure();
    test_async_reset();
    test_add("small", 16'h0003, 16'h0004, 17'h00007, EXP_SMALL_LAT, 1'b1);
    // Slice 2 carries into slice 3, so this pair always runs the full length
    test_add("mid_carry", 16'h0F00, 16'h0100, 17'h01000, 4, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 ns, want completion");
    $fatal(1);
  end

endmodule
